// File: rtl/plic_pkg.sv
// Shared PLIC definitions: source count, ID and edge-counter widths, and the
// per-source gateway state encoding used by both the gateway and the core.
package plic_pkg;

  localparam int N_INT_SRC  = 32;
  localparam int W_ID       = 5;
  localparam int W_EDGE_CNT = 3;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_src.sv
// One interrupt source: synchronizer, edge detect, IDLE/PENDING/CLAIMED FSM,
// queued-edge counter and sticky overflow flag.
module plic_gateway_src
  import plic_pkg::*;
#(
  parameter int SRC_ID     = 1,
  parameter int W_ID       = plic_pkg::W_ID,
  parameter int W_EDGE_CNT = plic_pkg::W_EDGE_CNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq,
  input  logic            edge_mode,
  input  logic            claim_valid,
  input  logic [W_ID-1:0] claim_id,
  input  logic            complete_valid,
  input  logic [W_ID-1:0] complete_id,
  input  logic            ovf_clr,
  output logic            pending,
  output logic            claimed,
  output logic            ovf,
  output gw_state_e       state
);

  localparam logic [W_EDGE_CNT-1:0] CNT_MAX = '1;
  localparam logic [W_EDGE_CNT-1:0] CNT_ONE = W_EDGE_CNT'(1);

  logic                  sync1_q, s2_q, s3_q;
  gw_state_e             state_q, state_d;
  logic [W_EDGE_CNT-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  pending_q, pending_d;
  logic                  claimed_q, claimed_d;
  logic                  edge_evt, claim_hit, complete_hit, requeue, ovf_hit;

  assign edge_evt     = s2_q & ~s3_q;
  assign claim_hit    = claim_valid && (claim_id == W_ID'(SRC_ID));
  assign complete_hit = complete_valid && (complete_id == W_ID'(SRC_ID));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    requeue = 1'b0;
    ovf_hit = 1'b0;
    case (state_q)
      GW_IDLE:    if (edge_mode ? edge_evt : s2_q) state_d = GW_PENDING;
      GW_PENDING: if (claim_hit) state_d = GW_CLAIMED;
      GW_CLAIMED: begin
        if (complete_hit) begin
          if (edge_mode && (cnt_q != '0)) begin
            // A fresh edge this cycle replaces the one being consumed.
            state_d = GW_PENDING;
            requeue = 1'b1;
            cnt_d   = edge_evt ? cnt_q : cnt_q - CNT_ONE;
          end else if (!edge_mode && s2_q) begin
            state_d = GW_PENDING;
          end else begin
            state_d = GW_IDLE;
          end
        end
      end
      default: state_d = GW_IDLE;
    endcase

    if (edge_mode && edge_evt && (state_q != GW_IDLE) && !requeue) begin
      if (cnt_q == CNT_MAX) ovf_hit = 1'b1;
      else                  cnt_d   = cnt_q + CNT_ONE;
    end
    if (!edge_mode) cnt_d = '0;

    // A new overflow beats a simultaneous clear.
    if (ovf_hit)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    pending_d = (state_d == GW_PENDING);
    claimed_d = (state_d == GW_CLAIMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= GW_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pending_q <= 1'b0;
      claimed_q <= 1'b0;
    end else begin
      sync1_q   <= irq;
      s2_q      <= sync1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
      claimed_q <= claimed_d;
    end
  end

  assign pending = pending_q;
  assign claimed = claimed_q;
  assign ovf     = ovf_q;
  assign state   = state_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: one plic_gateway_src per source 1..N_INT_SRC-1;
// source 0 is reserved and its outputs are tied low.
module plic_gateway #(
  parameter int N_INT_SRC  = plic_pkg::N_INT_SRC,
  parameter int W_ID       = plic_pkg::W_ID,
  parameter int W_EDGE_CNT = plic_pkg::W_EDGE_CNT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_INT_SRC-1:0]   w_irq_src,
  input  logic [N_INT_SRC-1:0]   w_edge_mode,
  input  logic                   w_claim_valid,
  input  logic [W_ID-1:0]        w_claim_id,
  input  logic                   w_complete_valid,
  input  logic [W_ID-1:0]        w_complete_id,
  input  logic                   w_ovf_clr,
  output logic [N_INT_SRC-1:0]   w_pending,
  output logic [N_INT_SRC-1:0]   w_claimed,
  output logic [N_INT_SRC-1:0]   w_ovf,
  output logic [2*N_INT_SRC-1:0] w_dbg_state
);

  logic unused_src0;
  assign unused_src0 = w_irq_src[0] ^ w_edge_mode[0];

  assign w_pending[0]     = 1'b0;
  assign w_claimed[0]     = 1'b0;
  assign w_ovf[0]         = 1'b0;
  assign w_dbg_state[1:0] = 2'b00;

  for (genvar i = 1; i < N_INT_SRC; i++) begin : g_src
    plic_gateway_src #(
      .SRC_ID    (i),
      .W_ID      (W_ID),
      .W_EDGE_CNT(W_EDGE_CNT)
    ) u_src (
      .clk           (CLK),
      .rst           (RST),
      .irq           (w_irq_src[i]),
      .edge_mode     (w_edge_mode[i]),
      .claim_valid   (w_claim_valid),
      .claim_id      (w_claim_id),
      .complete_valid(w_complete_valid),
      .complete_id   (w_complete_id),
      .ovf_clr       (w_ovf_clr),
      .pending       (w_pending[i]),
      .claimed       (w_claimed[i]),
      .ovf           (w_ovf[i]),
      .state         (w_dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboarded bench for plic_gateway: directed service scenarios followed by
// randomized traffic, all checked against a per-source behavioural model.
module tb_plic_gateway;

  localparam int NS   = 32;
  localparam int WI   = 5;
  localparam int CMAX = 7;
  localparam int W    = 3 * NS;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NS-1:0] w_irq_src = '0;
  logic [NS-1:0] w_edge_mode = '0;
  logic          w_claim_valid = 1'b0;
  logic [WI-1:0] w_claim_id = '0;
  logic          w_complete_valid = 1'b0;
  logic [WI-1:0] w_complete_id = '0;
  logic          w_ovf_clr = 1'b0;
  logic [NS-1:0] w_pending, w_claimed, w_ovf;
  logic [2*NS-1:0] unused_dbg_state;

  plic_gateway dut (
    .CLK             (CLK),
    .RST             (RST),
    .w_irq_src       (w_irq_src),
    .w_edge_mode     (w_edge_mode),
    .w_claim_valid   (w_claim_valid),
    .w_claim_id      (w_claim_id),
    .w_complete_valid(w_complete_valid),
    .w_complete_id   (w_complete_id),
    .w_ovf_clr       (w_ovf_clr),
    .w_pending       (w_pending),
    .w_claimed       (w_claimed),
    .w_ovf           (w_ovf),
    .w_dbg_state     (unused_dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each source is "waiting", "requesting" or "in service",
  // plus how many extra edges are queued behind it.
  bit m_d1[NS], m_d2[NS], m_d3[NS];
  bit m_req[NS], m_srv[NS], m_ovf[NS];
  int m_q[NS];

  task automatic model_step();
    if (RST) begin
      for (int i = 0; i < NS; i++) begin
        m_d1[i] = 0; m_d2[i] = 0; m_d3[i] = 0;
        m_req[i] = 0; m_srv[i] = 0; m_ovf[i] = 0; m_q[i] = 0;
      end
    end else begin
      for (int i = 1; i < NS; i++) begin
        bit ev, em, chit, dhit, served_again, req, srv;
        int q;
        ev   = m_d2[i] && !m_d3[i];
        em   = w_edge_mode[i];
        chit = w_claim_valid && (int'(w_claim_id) == i);
        dhit = w_complete_valid && (int'(w_complete_id) == i);
        req  = m_req[i];
        srv  = m_srv[i];
        q    = m_q[i];
        served_again = 0;
        if (!req && !srv) begin
          if (em ? ev : m_d2[i]) req = 1;
        end else if (req) begin
          if (chit) begin req = 0; srv = 1; end
        end else if (dhit) begin
          srv = 0;
          if (em && q > 0) begin
            req = 1; served_again = 1;
            if (!ev) q = q - 1;
          end else if (!em && m_d2[i]) begin
            req = 1;
          end
        end
        if (em && ev && (m_req[i] || m_srv[i]) && !served_again) begin
          if (q == CMAX) m_ovf[i] = 1;
          else q = q + 1;
        end else if (w_ovf_clr) begin
          m_ovf[i] = 0;
        end
        if (w_ovf_clr && !(em && ev && (m_req[i] || m_srv[i]) && !served_again && m_q[i] == CMAX))
          m_ovf[i] = 0;
        if (!em) q = 0;
        m_req[i] = req; m_srv[i] = srv; m_q[i] = q;
      end
      for (int i = 0; i < NS; i++) begin
        m_d3[i] = m_d2[i]; m_d2[i] = m_d1[i]; m_d1[i] = w_irq_src[i];
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [NS-1:0] p, c, o;
    for (int i = 0; i < NS; i++) begin
      p[i] = m_req[i]; c[i] = m_srv[i]; o[i] = m_ovf[i];
    end
    return {p, c, o};
  endfunction

  // driver tasks
  task automatic tick();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_claim(input int id);
    w_claim_valid = 1'b1; w_claim_id = WI'(id);
    tick();
    w_claim_valid = 1'b0; w_claim_id = '0;
  endtask

  task automatic do_complete(input int id);
    w_complete_valid = 1'b1; w_complete_id = WI'(id);
    tick();
    w_complete_valid = 1'b0; w_complete_id = '0;
  endtask

  task automatic pulse(input int s);
    w_irq_src[s] = 1'b1; tick();
    w_irq_src[s] = 1'b0; tick();
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick_src(input bit want_srv);
    int s;
    s = $urandom_range(1, NS - 1);
    for (int k = 0; k < NS - 1; k++) begin
      int j;
      j = ((s - 1 + k) % (NS - 1)) + 1;
      if (want_srv ? m_srv[j] : m_req[j]) return j;
    end
    return $urandom_range(0, NS - 1);
  endfunction

  // scoreboard monitor: one registered output vector per clock
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge CLK);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {w_pending, w_claimed, w_ovf};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL scoreboard cyc=%0d got p/c/o=%h want %h", cyc, a, e);
        end
      end
    end
  end

  initial begin
    #1;
    RST = 1'b1; idle(2); RST = 1'b0;
    chk("reset_pending3", w_pending[3], 1'b0);
    w_edge_mode = 32'h0000_00A4;

    // level source 3: latency, claim, re-request on complete
    w_irq_src[3] = 1'b1;
    idle(2); chk("lvl_lat_2", w_pending[3], 1'b0);
    idle(1); chk("lvl_lat_3", w_pending[3], 1'b1);
    do_claim(3);
    chk("lvl_claim_p", w_pending[3], 1'b0);
    chk("lvl_claim_c", w_claimed[3], 1'b1);
    do_complete(3); chk("lvl_rereq", w_pending[3], 1'b1);
    do_claim(3);

    // illegal handshakes
    w_irq_src[4] = 1'b1; idle(3); chk("src4_pend", w_pending[4], 1'b1);
    do_claim(0);  chk("claim0_c0", w_claimed[0], 1'b0);
    do_claim(9);  chk("claim9_c", w_claimed[9], 1'b0);
    chk("claim9_p", w_pending[9], 1'b0);
    do_complete(4);
    chk("cmpl4_p", w_pending[4], 1'b1);
    chk("cmpl4_c", w_claimed[4], 1'b0);
    w_irq_src[4] = 1'b0; idle(3); chk("lvl_hold", w_pending[4], 1'b1);

    // edge source 5: four queued edges drained by claim/complete pairs
    pulse(5); idle(1); chk("edge5_pend", w_pending[5], 1'b1);
    do_claim(5);
    repeat (4) pulse(5);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      do_complete(5); chk("edge5_requeue", w_pending[5], 1'b1);
      do_claim(5);    chk("edge5_claim", w_claimed[5], 1'b1);
    end
    do_complete(5);
    chk("edge5_idle_p", w_pending[5], 1'b0);
    chk("edge5_idle_c", w_claimed[5], 1'b0);

    // edge source 7: saturation, overflow, clear, overflow beats clear
    pulse(7); idle(1); do_claim(7);
    repeat (7) pulse(7);
    idle(2); chk("ovf7_pre", w_ovf[7], 1'b0);
    pulse(7); idle(2); chk("ovf7_set", w_ovf[7], 1'b1);
    w_ovf_clr = 1'b1; tick(); w_ovf_clr = 1'b0;
    chk("ovf7_clr", w_ovf[7], 1'b0);
    w_irq_src[7] = 1'b1; tick(); w_irq_src[7] = 1'b0; tick();
    w_ovf_clr = 1'b1; tick(); w_ovf_clr = 1'b0;
    chk("ovf7_wins", w_ovf[7], 1'b1);

    // simultaneous events on sources 2 and 6
    pulse(2); idle(1); do_claim(2);
    pulse(2); idle(2);
    w_irq_src[2] = 1'b1; tick(); w_irq_src[2] = 1'b0; tick();
    do_complete(2); chk("edge2_coinc", w_pending[2], 1'b1);
    w_irq_src[6] = 1'b1; idle(3); do_claim(6);
    w_irq_src[6] = 1'b0; idle(3);
    w_claim_valid = 1'b1; w_claim_id = 5'd2;
    w_complete_valid = 1'b1; w_complete_id = 5'd6;
    tick();
    w_claim_valid = 1'b0; w_complete_valid = 1'b0;
    chk("dual_c2", w_claimed[2], 1'b1);
    chk("dual_c6", w_claimed[6], 1'b0);
    chk("dual_p6", w_pending[6], 1'b0);
    do_complete(2); chk("edge2_cnt1", w_pending[2], 1'b1);
    do_claim(2); do_complete(2);
    chk("edge2_idle", w_pending[2] | w_claimed[2], 1'b0);

    // reset mid-service
    pulse(5); idle(1); do_claim(5);
    pulse(5); pulse(5); idle(2);
    chk("pre_rst_c3", w_claimed[3], 1'b1);
    RST = 1'b1; tick();
    chk("rst_all_zero", |{w_pending, w_claimed, w_ovf}, 1'b0);
    RST = 1'b0;
    idle(2); chk("rst_rereq_2", w_pending[3], 1'b0);
    idle(1); chk("rst_rereq_3", w_pending[3], 1'b1);

    // randomized traffic
    RST = 1'b1; tick(); RST = 1'b0;
    w_irq_src = '0;
    for (int t = 0; t < 500; t++) begin
      if (t % 60 == 0) w_edge_mode = $urandom;
      w_irq_src = w_irq_src ^ ($urandom & $urandom & $urandom);
      w_claim_valid = ($urandom_range(0, 2) == 0);
      w_claim_id = ($urandom_range(0, 4) == 0) ? WI'($urandom_range(0, NS - 1))
                                               : WI'(pick_src(1'b0));
      w_complete_valid = ($urandom_range(0, 2) == 0);
      w_complete_id = ($urandom_range(0, 4) == 0) ? WI'($urandom_range(0, NS - 1))
                                                  : WI'(pick_src(1'b1));
      w_ovf_clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0) RST = 1'b1;
      tick();
      RST = 1'b0;
    end
    w_claim_valid = 1'b0; w_complete_valid = 1'b0; w_ovf_clr = 1'b0;

    repeat (3) @(negedge CLK);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/plic_gateway.md
PLIC_GATEWAY -- requirements
Module: plic_gateway

Interface
REQ-001 Parameter N_INT_SRC, default 32: number of interrupt sources; ID 0 is reserved and carries no interrupt.
REQ-002 Parameter W_ID, default 5: width of claim/complete IDs, equal to clog2(N_INT_SRC).
REQ-003 Parameter W_EDGE_CNT, default 3: width of the per-source queued-edge counter.
REQ-004 CLK  input  1: the single clock; all logic is on the rising edge.
REQ-005 RST  input  1: synchronous, active-high reset.
REQ-006 w_irq_src  input  N_INT_SRC: raw, asynchronous device interrupt lines.
REQ-007 w_edge_mode  input  N_INT_SRC: per-source trigger mode; 1 = rising-edge, 0 = level-high.
REQ-008 w_claim_valid / w_claim_id  input  1 / W_ID: one-cycle claim notification from the PLIC core.
REQ-009 w_complete_valid / w_complete_id  input  1 / W_ID: one-cycle completion notification from the PLIC core.
REQ-010 w_ovf_clr  input  1: one-cycle pulse that clears all overflow flags.
REQ-011 w_pending  output  N_INT_SRC: gateway request lines feeding the PLIC core's pending bits.
REQ-012 w_claimed  output  N_INT_SRC: per-source in-service status.
REQ-013 w_ovf  output  N_INT_SRC: sticky per-source edge-counter overflow flags.

Function
REQ-014 Each source passes through a 2-flop synchronizer, giving s2, plus a delay flop s3; edge event = s2 & ~s3.
REQ-015 Each source runs an FSM with states IDLE, PENDING and CLAIMED; w_pending[i] = (state==PENDING) and w_claimed[i] = (state==CLAIMED), both registered.
REQ-016 IDLE->PENDING occurs on an edge event (edge mode) or when s2==1 (level mode).
REQ-017 Latency: a raw line held high across 3 rising edges asserts w_pending[i] after the 3rd edge.
REQ-018 PENDING->CLAIMED occurs when w_claim_valid && w_claim_id==i; w_pending[i] deasserts the next cycle.
REQ-019 CLAIMED exit occurs on w_complete_valid && w_complete_id==i, with the following destinations.
- Edge mode, counter>0: go to PENDING and decrement the counter.
- Level mode with s2==1: go to PENDING.
- Otherwise: go to IDLE.
REQ-020 A claim for a source not in PENDING, a complete for a source not in CLAIMED, and any ID 0 or ID >= N_INT_SRC shall be ignored with no state change.
REQ-021 In edge mode, an edge event while in PENDING or CLAIMED shall increment the counter, saturating at 2^W_EDGE_CNT-1.
REQ-022 An edge event at saturation shall set w_ovf[i].
REQ-023 An edge event in the same cycle as a CLAIMED->PENDING completion shall leave the counter unchanged.
REQ-024 An edge event in IDLE shall go to PENDING without incrementing the counter.
REQ-025 While w_edge_mode[i]==0, the counter for source i shall be held at 0.
- A mode change does not alter the FSM state.
REQ-026 w_ovf[i] is sticky; w_ovf_clr clears all flags, and an overflow in the same cycle as w_ovf_clr shall win (flag remains set).
REQ-027 w_pending[0], w_claimed[0] and w_ovf[0] shall be constant 0.
REQ-028 Level mode: deassertion of the line while in PENDING shall not withdraw the request; the FSM stays in PENDING until claimed.

Reset
REQ-029 On RST, all synchronizer flops, s3, counters, FSMs (to IDLE) and w_ovf shall clear to 0 in the same cycle.
- All outputs read 0 the cycle after RST is sampled high.
REQ-030 RST asserted mid-service shall discard all claims and queued edges.
- A level source still high re-requests 3 cycles after RST deasserts.

Structure
REQ-031 N_INT_SRC, W_ID, W_EDGE_CNT and the IDLE/PENDING/CLAIMED state encoding shall live in the shared package plic_pkg, reused by the PLIC core.
REQ-032 Per-source logic shall be the sub-module plic_gateway_src, covering synchronizer, edge detect, FSM, counter and overflow flag.
- It is instantiated N_INT_SRC-1 times by generate, decoding claim/complete IDs against its own index.

Verification
REQ-033 Level source 3: src[3] high at cycle 0 -> w_pending[3]=1 after cycle 3; claim ID 3 -> pending 0 and claimed[3]=1 next cycle; complete ID 3 with src still high -> pending[3]=1 the next cycle.
REQ-034 Edge source 5: 4 pulses while CLAIMED -> counter=4; 4 successive claim/complete pairs each re-raise pending; after the 5th complete -> IDLE, pending 0.
REQ-035 Edge source 7, W_EDGE_CNT=3: 8 edges while CLAIMED -> counter saturates at 7 and w_ovf[7]=1; w_ovf_clr -> 0; overflow coincident with clr -> remains 1.
REQ-036 Illegal handshakes: claim ID 0, claim ID 9 while idle, and complete ID 4 while PENDING -> no output change on any bit.
REQ-037 Simultaneous events: edge on source 2 coincident with its complete while counter=1 -> PENDING with counter still 1.
- Claim for source 2 coincident with complete for source 6 -> both transition independently.
REQ-038 Reset mid-service: RST pulse while sources 3 and 5 are CLAIMED and counters nonzero -> all outputs 0 next cycle; level src[3] still high -> pending[3]=1 three cycles after RST drops.
